// File: rtl/control_multdiv_stall.sv
// Stall/handshake controller for the X-stage multi-cycle multiplier and divider.
// Issues one start pulse per MUL/DIV and holds the pipeline until ready or the per-op limit.
module control_multdiv_stall #(
  parameter logic [4:0] ALU_OPCODE = 5'b00000,
  parameter logic [4:0] MUL_ALUOP  = 5'b00110,
  parameter logic [4:0] DIV_ALUOP  = 5'b00111,
  parameter int         MUL_MAX    = 17,
  parameter int         DIV_MAX    = 33,
  parameter int         CNT_W      = 6
) (
  input  logic             cpu_clock,
  input  logic             reset_n,
  input  logic [31:0]      instruction_X,
  input  logic             x_valid,
  input  logic             flush,
  input  logic             outside_stall,
  input  logic             mult_rdy,
  input  logic             div_rdy,
  input  logic             mult_exc,
  input  logic             div_exc,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             stall,
  output logic             result_we,
  output logic             result_sel,
  output logic             md_exception,
  output logic             timeout,
  output logic [CNT_W-1:0] busy_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] MUL_LIM = CNT_W'(MUL_MAX);
  localparam logic [CNT_W-1:0] DIV_LIM = CNT_W'(DIV_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       is_mul_op;
  logic       is_div_op;
  logic       is_md;
  logic       sel_rdy;
  logic       sel_exc;
  logic       at_lim;
  logic       done;

  // Register/immediate fields play no part in the decode.
  logic unused_fields;
  assign unused_fields = ^{instruction_X[26:7], instruction_X[1:0]};

  assign is_mul_op = (instruction_X[31:27] == ALU_OPCODE) && (instruction_X[6:2] == MUL_ALUOP);
  assign is_div_op = (instruction_X[31:27] == ALU_OPCODE) && (instruction_X[6:2] == DIV_ALUOP);
  assign is_md     = x_valid & ~flush & (is_mul_op | is_div_op);

  // Only the unit latched at start is listened to; the other unit's handshake is ignored.
  assign sel_rdy = result_sel ? div_rdy : mult_rdy;
  assign sel_exc = result_sel ? div_exc : mult_exc;
  assign at_lim  = (busy_count == (result_sel ? DIV_LIM : MUL_LIM));
  assign done    = sel_rdy | at_lim;

  always_comb begin
    state_nxt    = state;
    ctrl_mult    = 1'b0;
    ctrl_div     = 1'b0;
    stall        = 1'b0;
    result_we    = 1'b0;
    md_exception = 1'b0;
    timeout      = 1'b0;
    case (state)
      IDLE: begin
        if (is_md) begin
          ctrl_mult = is_mul_op;
          ctrl_div  = is_div_op;
          stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A squash outranks completion: the op is abandoned without writing back.
        if (flush) begin
          state_nxt = IDLE;
        end else if (done) begin
          result_we    = 1'b1;
          md_exception = sel_exc;
          timeout      = ~sel_rdy;
          state_nxt    = DONE;
        end else begin
          stall = 1'b1;
        end
      end
      DONE: begin
        // The finished instruction is still in X while the pipeline is held elsewhere.
        if (!outside_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy_count <= '0;
      result_sel <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && is_md) begin
        busy_count <= '0;
        result_sel <= is_div_op;
      end else if (state == BUSY) begin
        busy_count <= sat_inc(busy_count);
      end
    end
  end

endmodule

// File: tb/tb_control_multdiv_stall.sv
// Randomized and directed bench for control_multdiv_stall against an op-level reference model.
module tb_control_multdiv_stall;

  localparam int         CNT_W  = 6;
  localparam logic [4:0] MUL_OP = 5'b00110;
  localparam logic [4:0] DIV_OP = 5'b00111;

  logic             cpu_clock = 1'b0;
  logic             reset_n;
  logic [31:0]      instruction_X;
  logic             x_valid;
  logic             flush;
  logic             outside_stall;
  logic             mult_rdy;
  logic             div_rdy;
  logic             mult_exc;
  logic             div_exc;
  logic             ctrl_mult;
  logic             ctrl_div;
  logic             stall;
  logic             result_we;
  logic             result_sel;
  logic             md_exception;
  logic             timeout;
  logic [CNT_W-1:0] busy_count;

  control_multdiv_stall #(
    .ALU_OPCODE(5'b00000),
    .MUL_ALUOP (MUL_OP),
    .DIV_ALUOP (DIV_OP),
    .MUL_MAX   (17),
    .DIV_MAX   (33),
    .CNT_W     (CNT_W)
  ) dut (
    .cpu_clock    (cpu_clock),
    .reset_n      (reset_n),
    .instruction_X(instruction_X),
    .x_valid      (x_valid),
    .flush        (flush),
    .outside_stall(outside_stall),
    .mult_rdy     (mult_rdy),
    .div_rdy      (div_rdy),
    .mult_exc     (mult_exc),
    .div_exc      (div_exc),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .stall        (stall),
    .result_we    (result_we),
    .result_sel   (result_sel),
    .md_exception (md_exception),
    .timeout      (timeout),
    .busy_count   (busy_count)
  );

  always #5 cpu_clock = ~cpu_clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one outstanding op, how long it has run, and whether it still blocks X.
  bit m_known   = 1'b0;
  bit m_active  = 1'b0;
  bit m_blocked = 1'b0;
  bit m_sel     = 1'b0;
  bit m_cnt_ok  = 1'b0;
  int m_cnt     = 0;

  int obs_mult, obs_div, obs_stall, obs_we, obs_exc;
  int we_cnt;
  bit we_sel, we_to, we_exc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] opc, input logic [4:0] aluop);
    logic [19:0] mid;
    logic [1:0]  low;
    mid = 20'($urandom);
    low = 2'($urandom);
    return {opc, mid, aluop, low};
  endfunction

  task automatic clr_obs();
    obs_mult = 0; obs_div = 0; obs_stall = 0; obs_we = 0; obs_exc = 0;
    we_cnt = -1; we_sel = 1'b0; we_to = 1'b0; we_exc = 1'b0;
  endtask

  // One clock: compare against the model just after the inputs settle, then advance the model.
  task automatic tick();
    logic md, isdiv, rdy, fin;
    logic e_mult, e_div, e_stall, e_we, e_exc, e_to;
    int lim;
    #1;
    isdiv = (instruction_X[6:2] == DIV_OP);
    md = x_valid && !flush && (instruction_X[31:27] == 5'd0) &&
         ((instruction_X[6:2] == MUL_OP) || isdiv);
    lim = m_sel ? 33 : 17;
    rdy = m_sel ? div_rdy : mult_rdy;
    fin = rdy || (m_cnt == lim);
    {e_mult, e_div, e_stall, e_we, e_exc, e_to} = '0;
    if (!m_active && !m_blocked) begin
      if (md) begin
        e_mult = !isdiv; e_div = isdiv; e_stall = 1'b1;
      end
    end else if (m_active && !flush) begin
      if (fin) begin
        e_we = 1'b1; e_exc = m_sel ? div_exc : mult_exc; e_to = !rdy;
      end else begin
        e_stall = 1'b1;
      end
    end
    if (m_known) begin
      check_val("ctrl_mult", 32'(ctrl_mult), 32'(e_mult));
      check_val("ctrl_div", 32'(ctrl_div), 32'(e_div));
      check_val("stall", 32'(stall), 32'(e_stall));
      check_val("result_we", 32'(result_we), 32'(e_we));
      check_val("md_exception", 32'(md_exception), 32'(e_exc));
      check_val("timeout", 32'(timeout), 32'(e_to));
      check_val("result_sel", 32'(result_sel), 32'(m_sel));
      if (m_cnt_ok) check_val("busy_count", 32'(busy_count), 32'(m_cnt));
    end
    obs_mult  += int'(ctrl_mult);
    obs_div   += int'(ctrl_div);
    obs_stall += int'(stall);
    obs_we    += int'(result_we);
    obs_exc   += int'(md_exception);
    if (result_we) begin
      we_cnt = int'(busy_count); we_sel = result_sel; we_to = timeout; we_exc = md_exception;
    end
    @(posedge cpu_clock);
    if (!reset_n) begin
      m_known = 1'b1; m_active = 1'b0; m_blocked = 1'b0; m_sel = 1'b0;
      m_cnt = 0; m_cnt_ok = 1'b1;
    end else if (m_active) begin
      if (flush) begin
        m_active = 1'b0; m_cnt_ok = 1'b0;
      end else if (fin) begin
        m_active = 1'b0; m_blocked = 1'b1; m_cnt_ok = 1'b0;
      end else begin
        m_cnt++;
      end
    end else if (m_blocked) begin
      m_blocked = outside_stall;
    end else if (md) begin
      m_active = 1'b1; m_sel = isdiv; m_cnt = 0; m_cnt_ok = 1'b1;
    end
    @(negedge cpu_clock);
  endtask

  task automatic idle(input int n);
    x_valid = 1'b0; flush = 1'b0; outside_stall = 1'b0;
    mult_rdy = 1'b0; div_rdy = 1'b0; mult_exc = 1'b0; div_exc = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic quiet_check(input string tag);
    #1;
    check_val({tag, "_cnt"}, 32'(busy_count), 32'd0);
    check_val({tag, "_outs"}, 32'({ctrl_mult, ctrl_div, stall, result_we, md_exception, timeout}), 32'd0);
    check_val({tag, "_sel"}, 32'(result_sel), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; instruction_X = '0;
    @(negedge cpu_clock);
    idle(2);
    reset_n = 1'b1;
    quiet_check("reset");

    // DIV answering after ten busy cycles
    clr_obs();
    instruction_X = mk_instr(5'd0, DIV_OP); x_valid = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    div_rdy = 1'b1;
    tick();
    idle(2);
    check_val("t1_div_pulses", 32'(obs_div), 32'd1);
    check_val("t1_stall_cycles", 32'(obs_stall), 32'd11);
    check_val("t1_we_pulses", 32'(obs_we), 32'd1);
    check_val("t1_sel", 32'(we_sel), 32'd1);
    check_val("t1_timeout", 32'(we_to), 32'd0);

    // MUL that never answers
    clr_obs();
    instruction_X = mk_instr(5'd0, MUL_OP); x_valid = 1'b1; mult_exc = 1'b1;
    tick();
    for (int i = 0; i < 40 && obs_we == 0; i++) tick();
    idle(2);
    check_val("t2_mult_pulses", 32'(obs_mult), 32'd1);
    check_val("t2_we_pulses", 32'(obs_we), 32'd1);
    check_val("t2_we_count", 32'(we_cnt), 32'd17);
    check_val("t2_timeout", 32'(we_to), 32'd1);
    check_val("t2_exc", 32'(we_exc), 32'd1);
    check_val("t2_stall_cycles", 32'(obs_stall), 32'd18);

    // DIV with divide-by-zero
    clr_obs();
    instruction_X = mk_instr(5'd0, DIV_OP); x_valid = 1'b1; div_exc = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    div_rdy = 1'b1;
    tick();
    idle(2);
    check_val("t3_we_pulses", 32'(obs_we), 32'd1);
    check_val("t3_exc_at_we", 32'(we_exc), 32'd1);
    check_val("t3_exc_cycles", 32'(obs_exc), 32'd1);

    // flush three cycles into BUSY, then a fresh DIV
    clr_obs();
    instruction_X = mk_instr(5'd0, DIV_OP); x_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b1;
    tick();
    idle(1);
    check_val("t4_no_we", 32'(obs_we), 32'd0);
    check_val("t4_stall_cycles", 32'(obs_stall), 32'd4);
    x_valid = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) tick();
    div_rdy = 1'b1;
    tick();
    idle(2);
    check_val("t4_restart_pulses", 32'(obs_div), 32'd2);
    check_val("t4_restart_we", 32'(obs_we), 32'd1);

    // completed DIV held in X by an outside stall
    clr_obs();
    instruction_X = mk_instr(5'd0, DIV_OP); x_valid = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) tick();
    div_rdy = 1'b1;
    tick();
    div_rdy = 1'b0;
    clr_obs();
    outside_stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    outside_stall = 1'b0;
    tick();
    idle(1);
    check_val("t5_no_restart", 32'(obs_div), 32'd0);
    check_val("t5_no_stall", 32'(obs_stall), 32'd0);
    check_val("t5_no_we", 32'(obs_we), 32'd0);

    // reset in the middle of a MUL
    clr_obs();
    instruction_X = mk_instr(5'd0, MUL_OP); x_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    reset_n = 1'b0; x_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    quiet_check("t6_reset");
    idle(1);
    check_val("t6_no_we", 32'(obs_we), 32'd0);

    // multiplier ready during a DIV is ignored
    clr_obs();
    instruction_X = mk_instr(5'd0, DIV_OP); x_valid = 1'b1; mult_rdy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    div_rdy = 1'b1;
    tick();
    idle(2);
    check_val("t7_we_count", 32'(we_cnt), 32'd4);
    check_val("t7_we_pulses", 32'(obs_we), 32'd1);
    check_val("t7_timeout", 32'(we_to), 32'd0);

    // ready arriving exactly at the limit is not a timeout
    clr_obs();
    instruction_X = mk_instr(5'd0, MUL_OP); x_valid = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) tick();
    mult_rdy = 1'b1;
    tick();
    idle(2);
    check_val("t8_we_count", 32'(we_cnt), 32'd17);
    check_val("t8_timeout", 32'(we_to), 32'd0);
    check_val("t8_we_pulses", 32'(obs_we), 32'd1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 4)       instruction_X = mk_instr(5'd0, MUL_OP);
      else if (kind < 8)  instruction_X = mk_instr(5'd0, DIV_OP);
      else if (kind == 8) instruction_X = mk_instr(5'd0, 5'($urandom_range(0, 5)));
      else                instruction_X = mk_instr(5'($urandom_range(1, 31)), MUL_OP);
      x_valid       = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      outside_stall = ($urandom_range(0, 3) == 0);
      mult_rdy      = ($urandom_range(0, 15) == 0);
      div_rdy       = ($urandom_range(0, 15) == 0);
      mult_exc      = 1'($urandom);
      div_exc       = 1'($urandom);
      reset_n       = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
